// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the program counter, drives a request/acknowledge instruction-memory
// port and registers {pc, instruction, valid} into the IF/ID pipeline
// register. Handles downstream stall, taken branches with a delay slot and
// exception flush. A one-entry skid buffer holds an instruction that
// returns from memory while the pipeline is stalled.
//
// Optional build macro:
//   ADDR_ERR_EN  adds output if_excp_adel. A fetch from a PC whose low two
//                bits are non-zero is never issued. Instead the stage
//                reports an address-error exception for that PC and stays
//                quiet until the next flush. Without the macro the low PC
//                bits are ignored for alignment.
//
// Ports:
//   clk                   pipeline clock, rising edge
//   rst                   synchronous active-high reset
//   stall                 downstream hold from pipeline control
//   branch_flag_i         branch taken, from decode
//   branch_target_addr_i  branch target address
//   flush                 exception flush
//   new_pc                exception handler address
//   inst_req              fetch request to instruction memory
//   inst_addr             fetch address (word aligned PC)
//   inst_ack              memory accepted the request and returned data
//   inst_rdata            instruction word, valid while inst_ack is high
//   if_pc                 PC of the delivered instruction
//   if_inst               delivered instruction, 0 (nop) when not valid
//   if_valid              if_pc / if_inst hold a real instruction
//   if_excp_adel          (ADDR_ERR_EN only) instruction address error
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_addr_i,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
`ifdef ADDR_ERR_EN
    ,
    output logic        if_excp_adel
`endif
);

    // IDLE: one quiet cycle after reset. REQ: fetching at pc.
    // HOLD: skid buffer full, waiting for the stall to lift.
    // DROP: a request abandoned by a flush is still waiting for its ack.
    // AERR: misaligned PC reported, waiting for a flush.
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP,
        S_AERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redir_q, redir_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] if_pc_d;
    logic [31:0] if_inst_d;
    logic        if_valid_d;
`ifdef ADDR_ERR_EN
    logic        adel_d;
`endif

    logic        pc_misaligned;
    logic [31:0] fetch_addr;
    logic        xfer;
    logic        branch_take;
    logic [31:0] seq_pc;
    logic [31:0] next_fetch;

    // Alignment only matters when the address-error exception is built in.
    // Otherwise the low PC bits are simply masked off the fetch address.
`ifdef ADDR_ERR_EN
    assign pc_misaligned = (pc_q[1:0] != 2'b00);
`else
    assign pc_misaligned = 1'b0;
`endif
    assign fetch_addr = {pc_q[31:2], 2'b00};

    // A dropped request must keep presenting its original address until the
    // memory acknowledges it, even though pc already points at the handler.
    assign inst_req  = ((state_q == S_REQ) && !pc_misaligned) || (state_q == S_DROP);
    assign inst_addr = (state_q == S_DROP) ? drop_addr_q : fetch_addr;

    assign xfer        = inst_req & inst_ack;
    assign branch_take = branch_flag_i & ~stall & ~flush;
    // A branch seen in an earlier cycle (redir_q) steers the address after
    // the delay slot. A branch seen in the same cycle as the ack overrides it.
    assign seq_pc      = redir_q ? redir_tgt_q : (pc_q + 32'd4);
    assign next_fetch  = branch_take ? branch_target_addr_i : seq_pc;

    // Next-state and datapath logic. Flush is checked before anything else
    // and wipes every piece of speculative state. Branches and normal
    // progress are handled per state below it.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_d     = redir_q;
        redir_tgt_d = redir_tgt_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        drop_addr_d = drop_addr_q;
        if_pc_d     = if_pc;
        if_inst_d   = if_inst;
        if_valid_d  = if_valid;
`ifdef ADDR_ERR_EN
        adel_d      = if_excp_adel;
`endif

        if (flush) begin
            if_valid_d  = 1'b0;
            if_inst_d   = 32'h0;
            skid_pc_d   = 32'h0;
            skid_inst_d = 32'h0;
            redir_d     = 1'b0;
            pc_d        = new_pc;
`ifdef ADDR_ERR_EN
            adel_d      = 1'b0;
`endif
            if (inst_req && !inst_ack) begin
                state_d     = S_DROP;
                drop_addr_d = inst_addr;
            end else begin
                state_d     = S_REQ;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_REQ;
                end

                S_REQ: begin
                    if (pc_misaligned) begin
                        if (!stall) begin
                            if_pc_d    = pc_q;
                            if_inst_d  = 32'h0;
                            if_valid_d = 1'b0;
`ifdef ADDR_ERR_EN
                            adel_d     = 1'b1;
`endif
                            state_d    = S_AERR;
                        end
                    end else if (xfer) begin
                        pc_d    = next_fetch;
                        redir_d = 1'b0;
                        if (stall) begin
                            skid_pc_d   = pc_q;
                            skid_inst_d = inst_rdata;
                            state_d     = S_HOLD;
                        end else begin
                            if_pc_d    = pc_q;
                            if_inst_d  = inst_rdata;
                            if_valid_d = 1'b1;
                        end
                    end else begin
                        // The current request is the delay slot, so remember
                        // the target until it returns.
                        if (branch_take) begin
                            redir_d     = 1'b1;
                            redir_tgt_d = branch_target_addr_i;
                        end
                        if (!stall) begin
                            if_valid_d = 1'b0;
                            if_inst_d  = 32'h0;
                        end
                    end
                end

                S_HOLD: begin
                    if (!stall) begin
                        if_pc_d    = skid_pc_q;
                        if_inst_d  = skid_inst_q;
                        if_valid_d = 1'b1;
                        state_d    = S_REQ;
                        // The skid entry is the delay slot, and nothing is in
                        // flight, so the target can be loaded directly.
                        if (branch_take) begin
                            pc_d = branch_target_addr_i;
                        end
                    end
                end

                S_DROP: begin
                    if (inst_ack) begin
                        state_d = S_REQ;
                    end
                end

                S_AERR: begin
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Pipeline and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            redir_q      <= 1'b0;
            redir_tgt_q  <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_inst_q  <= 32'h0;
            drop_addr_q  <= 32'h0;
            if_pc        <= 32'h0;
            if_inst      <= 32'h0;
            if_valid     <= 1'b0;
`ifdef ADDR_ERR_EN
            if_excp_adel <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_q      <= redir_d;
            redir_tgt_q  <= redir_tgt_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
            drop_addr_q  <= drop_addr_d;
            if_pc        <= if_pc_d;
            if_inst      <= if_inst_d;
            if_valid     <= if_valid_d;
`ifdef ADDR_ERR_EN
            if_excp_adel <= adel_d;
`endif
        end
    end

endmodule
